// File: rtl/core_launch_pkg.sv
// Shared types and constants for the multicore launch sequencer.
// The mask map is fixed for a 16-core array.
package core_launch_pkg;

    localparam int N_CORES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [N_CORES-1:0] MASK_1       = 16'h0001;
    localparam logic [N_CORES-1:0] MASK_2       = 16'h0003;
    localparam logic [N_CORES-1:0] MASK_4       = 16'h0033;
    localparam logic [N_CORES-1:0] MASK_8       = 16'h00FF;
    localparam logic [N_CORES-1:0] MASK_16      = 16'hFFFF;
    localparam logic [N_CORES-1:0] MASK_DEFAULT = 16'h0033;

endpackage

// File: rtl/core_mask_decode.sv
// Combinational decode of a requested core count into the core-enable mask.
// Unsupported counts fall back to the 4-core pattern.
module core_mask_decode
    import core_launch_pkg::*;
(
    input  logic [4:0]         i_num_core,
    output logic [N_CORES-1:0] o_mask
);

    always_comb begin
        case (i_num_core)
            5'd1:    o_mask = MASK_1;
            5'd2:    o_mask = MASK_2;
            5'd4:    o_mask = MASK_4;
            5'd8:    o_mask = MASK_8;
            5'd16:   o_mask = MASK_16;
            default: o_mask = MASK_DEFAULT;
        endcase
    end

endmodule

// File: rtl/core_launch_ctrl.sv
// Launch sequencer: latches a core mask on start, powers masked cores on one at a
// time, waits for every masked core to report done, then drops all enables.
module core_launch_ctrl
    import core_launch_pkg::*;
#(
    parameter int RAMP_GAP       = 1,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [4:0]         num_core_i,
    input  logic               abort_i,
    input  logic [N_CORES-1:0] core_done_i,
    output logic [N_CORES-1:0] core_en_o,
    output logic [N_CORES-1:0] active_mask_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               timeout_o,
    output logic               aborted_o
);

    localparam int GAP_W = (RAMP_GAP > 1) ? $clog2(RAMP_GAP) : 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_t             r_state;
    logic [N_CORES-1:0] r_en;
    logic [N_CORES-1:0] r_mask;
    logic [N_CORES-1:0] r_sticky;
    logic [3:0]         r_ptr;
    logic [GAP_W-1:0]   r_gap;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_timeout;
    logic               r_aborted;

    state_t             w_state;
    logic [N_CORES-1:0] w_en;
    logic [N_CORES-1:0] w_mask;
    logic [N_CORES-1:0] w_sticky;
    logic [3:0]         w_ptr;
    logic [GAP_W-1:0]   w_gap;
    logic [TMO_W-1:0]   w_tmo;
    logic               w_timeout;
    logic               w_aborted;

    logic [N_CORES-1:0] w_dec_mask;
    logic [N_CORES-1:0] w_sticky_acc;
    logic               w_all_done;
    logic               w_tmo_hit;
    logic               w_gap_last;
    logic               w_ptr_masked;

    core_mask_decode u_mask_decode (
        .i_num_core (num_core_i),
        .o_mask     (w_dec_mask)
    );

    // Done reports are only ever recorded for masked cores, so the sticky set
    // equals the mask exactly when every launched core has finished.
    assign w_sticky_acc = r_sticky | (core_done_i & r_mask);
    assign w_all_done   = (w_sticky_acc == r_mask);
    assign w_tmo_hit    = (TIMEOUT_CYCLES != 0) &&
                          ((32'(r_tmo) + 32'd1) == 32'(TIMEOUT_CYCLES));
    assign w_gap_last   = (32'(r_gap) == 32'(RAMP_GAP - 1));
    assign w_ptr_masked = r_mask[r_ptr];

    always_comb begin
        w_state   = r_state;
        w_en      = r_en;
        w_mask    = r_mask;
        w_sticky  = r_sticky;
        w_ptr     = r_ptr;
        w_gap     = r_gap;
        w_tmo     = r_tmo;
        w_timeout = 1'b0;
        w_aborted = 1'b0;

        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_state  = RAMP;
                    w_mask   = w_dec_mask;
                    w_sticky = '0;
                    w_ptr    = '0;
                    w_gap    = '0;
                    w_tmo    = '0;
                end
            end

            RAMP: begin
                if (abort_i) begin
                    w_state   = IDLE;
                    w_en      = '0;
                    w_aborted = 1'b1;
                end else begin
                    w_sticky = w_sticky_acc;
                    if (w_ptr_masked && (r_gap == '0)) begin
                        w_en[r_ptr] = 1'b1;
                    end
                    // Masked slots dwell RAMP_GAP cycles, unmasked slots just one.
                    if (w_ptr_masked && !w_gap_last) begin
                        w_gap = r_gap + GAP_W'(1);
                    end else begin
                        w_gap = '0;
                        w_ptr = r_ptr + 4'd1;
                        if (r_ptr == 4'd15) begin
                            w_state = RUN;
                            w_tmo   = '0;
                        end
                    end
                end
            end

            RUN: begin
                if (abort_i) begin
                    w_state   = IDLE;
                    w_en      = '0;
                    w_aborted = 1'b1;
                end else begin
                    w_sticky = w_sticky_acc;
                    w_tmo    = r_tmo + TMO_W'(1);
                    if (w_all_done) begin
                        w_state = DONE;
                        w_en    = '0;
                    end else if (w_tmo_hit) begin
                        w_state   = IDLE;
                        w_en      = '0;
                        w_timeout = 1'b1;
                    end
                end
            end

            DONE: begin
                w_state = IDLE;
                w_en    = '0;
                if (abort_i) begin
                    w_aborted = 1'b1;
                end
            end

            default: begin
                w_state = IDLE;
                w_en    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_en      <= '0;
            r_mask    <= '0;
            r_sticky  <= '0;
            r_ptr     <= '0;
            r_gap     <= '0;
            r_tmo     <= '0;
            r_timeout <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_en      <= w_en;
            r_mask    <= w_mask;
            r_sticky  <= w_sticky;
            r_ptr     <= w_ptr;
            r_gap     <= w_gap;
            r_tmo     <= w_tmo;
            r_timeout <= w_timeout;
            r_aborted <= w_aborted;
        end
    end

    assign core_en_o     = r_en;
    assign active_mask_o = r_mask;
    assign busy_o        = (r_state != IDLE);
    assign done_o        = (r_state == DONE);
    assign timeout_o     = r_timeout;
    assign aborted_o     = r_aborted;

endmodule

// File: tb/tb_core_launch_ctrl.sv
// Directed bench for core_launch_ctrl: instance A runs with RAMP_GAP=1 and a
// 20-cycle timeout, instance B with RAMP_GAP=3 and no timeout.
module tb_core_launch_ctrl;

    logic        clk;
    logic        rst_n;

    logic        aStart, aAbort;
    logic [4:0]  aNum;
    logic [15:0] aDoneIn, aEn, aMask;
    logic        aBusy, aDone, aTimeout, aAborted;

    logic        bStart, bAbort;
    logic [4:0]  bNum;
    logic [15:0] bDoneIn, bEn, bMask;
    logic        bBusy, bDone, bTimeout, bAborted;

    int total = 0;
    int bad   = 0;

    core_launch_ctrl #(.RAMP_GAP(1), .TIMEOUT_CYCLES(20)) dutA (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (aStart),
        .num_core_i    (aNum),
        .abort_i       (aAbort),
        .core_done_i   (aDoneIn),
        .core_en_o     (aEn),
        .active_mask_o (aMask),
        .busy_o        (aBusy),
        .done_o        (aDone),
        .timeout_o     (aTimeout),
        .aborted_o     (aAborted)
    );

    core_launch_ctrl #(.RAMP_GAP(3), .TIMEOUT_CYCLES(0)) dutB (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (bStart),
        .num_core_i    (bNum),
        .abort_i       (bAbort),
        .core_done_i   (bDoneIn),
        .core_en_o     (bEn),
        .active_mask_o (bMask),
        .busy_o        (bBusy),
        .done_o        (bDone),
        .timeout_o     (bTimeout),
        .aborted_o     (bAborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input bit sel, input logic start, input logic [4:0] num,
                                 input logic abort, input logic [15:0] doneIn);
        if (!sel) begin
            aStart = start; aNum = num; aAbort = abort; aDoneIn = doneIn;
        end else begin
            bStart = start; bNum = num; bAbort = abort; bDoneIn = doneIn;
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 16'h0);
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 16'h0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        checkOutput("rst_en",      aEn,      32'h0);
        checkOutput("rst_mask",    aMask,    32'h0);
        checkOutput("rst_busy",    aBusy,    32'h0);
        checkOutput("rst_done",    aDone,    32'h0);
        checkOutput("rst_timeout", aTimeout, 32'h0);
        checkOutput("rst_aborted", aAborted, 32'h0);
        checkOutput("rst_b_en",    bEn,      32'h0);

        // Two cores, one-cycle stagger, completion on first RUN cycle.
        applyStimulus(1'b0, 1'b1, 5'd2, 1'b0, 16'h0);
        tick(1);
        checkOutput("t1_busy_e0", aBusy, 32'h1);
        checkOutput("t1_mask_e0", aMask, 32'h3);
        checkOutput("t1_en_e0",   aEn,   32'h0);
        applyStimulus(1'b0, 1'b0, 5'd2, 1'b0, 16'h0);
        tick(1);
        checkOutput("t1_en_e1", aEn, 32'h1);
        tick(1);
        checkOutput("t1_en_e2", aEn, 32'h3);
        applyStimulus(1'b0, 1'b1, 5'd16, 1'b0, 16'h0);
        tick(1);
        checkOutput("t1_start_ignored", aMask, 32'h3);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 16'h0);
        tick(13);
        checkOutput("t1_en_e16",   aEn,   32'h3);
        checkOutput("t1_done_e16", aDone, 32'h0);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 16'h0003);
        tick(1);
        checkOutput("t1_done_e17", aDone, 32'h1);
        checkOutput("t1_en_e17",   aEn,   32'h0);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 16'h0);
        tick(1);
        checkOutput("t1_done_e18", aDone, 32'h0);
        checkOutput("t1_busy_e18", aBusy, 32'h0);
        checkOutput("t1_mask_hold", aMask, 32'h3);

        // Done arriving on the very cycle the timeout would fire.
        applyStimulus(1'b0, 1'b1, 5'd1, 1'b0, 16'h0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 16'h0);
        tick(35);
        checkOutput("tw_en_e35",   aEn,   32'h1);
        checkOutput("tw_busy_e35", aBusy, 32'h1);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 16'h0001);
        tick(1);
        checkOutput("tw_done_wins",  aDone,    32'h1);
        checkOutput("tw_no_timeout", aTimeout, 32'h0);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 16'h0);
        tick(1);
        checkOutput("tw_busy_after", aBusy, 32'h0);

        // Eight cores, no done: timeout after 20 RUN cycles.
        applyStimulus(1'b0, 1'b1, 5'd8, 1'b0, 16'h0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 16'h0);
        tick(7);
        checkOutput("t4_en_e7", aEn, 32'h7F);
        tick(1);
        checkOutput("t4_en_e8", aEn, 32'hFF);
        tick(27);
        checkOutput("t4_en_e35",      aEn,      32'hFF);
        checkOutput("t4_timeout_e35", aTimeout, 32'h0);
        tick(1);
        checkOutput("t4_timeout_e36", aTimeout, 32'h1);
        checkOutput("t4_en_e36",      aEn,      32'h0);
        checkOutput("t4_busy_e36",    aBusy,    32'h0);
        tick(1);
        checkOutput("t4_timeout_e37", aTimeout, 32'h0);

        // Abort mid-ramp with a simultaneous start request.
        applyStimulus(1'b0, 1'b1, 5'd8, 1'b0, 16'h0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 16'h0);
        tick(4);
        checkOutput("t5_en_e4", aEn, 32'hF);
        applyStimulus(1'b0, 1'b1, 5'd1, 1'b1, 16'h0);
        tick(1);
        checkOutput("t5_en_abort",  aEn,      32'h0);
        checkOutput("t5_aborted",   aAborted, 32'h1);
        checkOutput("t5_busy",      aBusy,    32'h0);
        checkOutput("t5_mask_kept", aMask,    32'hFF);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 16'h0);
        tick(1);
        checkOutput("t5_aborted_end", aAborted, 32'h0);
        checkOutput("t5_busy_end",    aBusy,    32'h0);

        // Four cores with a three-cycle stagger; done before enable still counts.
        applyStimulus(1'b1, 1'b1, 5'd4, 1'b0, 16'h0);
        tick(1);
        checkOutput("t2_mask", bMask, 32'h33);
        checkOutput("t2_busy", bBusy, 32'h1);
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 16'h0);
        tick(1);
        checkOutput("t2_en_e1", bEn, 32'h1);
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 16'h0002);
        tick(1);
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 16'h0);
        tick(1);
        checkOutput("t2_en_e3", bEn, 32'h1);
        tick(1);
        checkOutput("t2_en_e4", bEn, 32'h3);
        tick(4);
        checkOutput("t2_en_e8", bEn, 32'h3);
        tick(1);
        checkOutput("t2_en_e9", bEn, 32'h13);
        tick(3);
        checkOutput("t2_en_e12", bEn, 32'h33);
        tick(12);
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 16'hFFCC);
        tick(1);
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 16'h0);
        tick(1);
        checkOutput("t2_unmasked_ignored", bDone, 32'h0);
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 16'h0001);
        tick(1);
        checkOutput("t2_partial", bDone, 32'h0);
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 16'h0030);
        tick(1);
        checkOutput("t2_done", bDone, 32'h1);
        checkOutput("t2_en_off", bEn, 32'h0);
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 16'h0);
        tick(1);
        checkOutput("t2_done_end", bDone, 32'h0);
        checkOutput("t2_busy_end", bBusy, 32'h0);

        // Mask fallback for unsupported counts, and a full 16-core ramp.
        applyStimulus(1'b1, 1'b1, 5'd5, 1'b0, 16'h0);
        tick(1);
        checkOutput("t3_mask_n5", bMask, 32'h33);
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 16'h0);
        tick(1);
        checkOutput("t3_aborted_n5", bAborted, 32'h1);
        applyStimulus(1'b1, 1'b1, 5'd0, 1'b0, 16'h0);
        tick(1);
        checkOutput("t3_mask_n0", bMask, 32'h33);
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 16'h0);
        tick(1);
        checkOutput("t3_busy_n0", bBusy, 32'h0);
        applyStimulus(1'b1, 1'b1, 5'd16, 1'b0, 16'h0);
        tick(1);
        checkOutput("t3_mask_n16", bMask, 32'hFFFF);
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 16'h0);
        tick(45);
        checkOutput("t3_en_e45", bEn, 32'h7FFF);
        tick(1);
        checkOutput("t3_en_e46", bEn, 32'hFFFF);
        tick(2);
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 16'hFFFF);
        tick(1);
        checkOutput("t3_done_e49", bDone, 32'h1);
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 16'h0);
        tick(1);
        checkOutput("t3_busy_e50", bBusy, 32'h0);

        // Asynchronous reset in the middle of RUN, then a clean relaunch.
        applyStimulus(1'b0, 1'b1, 5'd1, 1'b0, 16'h0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 16'h0);
        tick(18);
        checkOutput("t6_en_run", aEn, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6_en_async",   aEn,   32'h0);
        checkOutput("t6_busy_async", aBusy, 32'h0);
        checkOutput("t6_mask_async", aMask, 32'h0);
        #2 rst_n = 1'b1;
        tick(1);
        checkOutput("t6_no_abort_pulse", aAborted, 32'h0);
        checkOutput("t6_no_done_pulse",  aDone,    32'h0);
        applyStimulus(1'b0, 1'b1, 5'd2, 1'b0, 16'h0);
        tick(1);
        checkOutput("t6_relaunch_mask", aMask, 32'h3);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 16'h0);
        tick(1);
        checkOutput("t6_relaunch_en", aEn, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
